// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE-array sequencer: FSM state encoding,
// product pipeline latency and the default accumulator type.
package pe_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_OUTPUT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int PE_LAT        = 2;
  localparam int ACC_WIDTH_DEF = 32;

  typedef logic signed [ACC_WIDTH_DEF-1:0] acc_t;

endpackage

// File: rtl/pe_array_sequencer_if.sv
// Result-tile stream between the sequencer (master) and the downstream consumer (slave).
interface pe_array_sequencer_if #(
  parameter int NUM_PE    = 8,
  parameter int ACC_WIDTH = 32
);

  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [NUM_PE*ACC_WIDTH-1:0] out_data_o;
  logic [15:0]                 out_row_o;

  modport master (output out_valid_o, output out_data_o, output out_row_o, input out_ready_i);
  modport slave  (input out_valid_o, input out_data_o, input out_row_o, output out_ready_i);

endinterface

// File: rtl/pe_seq_addr_gen.sv
// k / tile counters for the sequencer: weight and activation read addresses,
// first/last-k markers and the last-tile flag.
module pe_seq_addr_gen
  import pe_seq_pkg::*;
#(
  parameter int NUM_PE     = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step_k,
  input  logic                  step_tile,
  input  logic [15:0]           rows,
  input  logic [15:0]           cols,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic [15:0]           row_base,
  output logic                  first_k,
  output logic                  last_k,
  output logic                  last_tile
);

  logic [15:0]           k;
  logic [ADDR_WIDTH-1:0] base;

  // base tracks tile*K incrementally so no multiplier is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= '0;
      base     <= '0;
      row_base <= '0;
    end else if (load) begin
      k        <= '0;
      base     <= '0;
      row_base <= '0;
    end else if (step_tile) begin
      k        <= '0;
      base     <= base + ADDR_WIDTH'(cols);
      row_base <= row_base + 16'(NUM_PE);
    end else if (step_k && !last_k) begin
      k <= k + 16'd1;
    end
  end

  assign w_addr    = base + ADDR_WIDTH'(k);
  assign x_addr    = ADDR_WIDTH'(k);
  assign first_k   = (k == 16'd0);
  assign last_k    = (k == cols - 16'd1);
  assign last_tile = ({1'b0, row_base} + 17'(NUM_PE)) >= {1'b0, rows};

endmodule

// File: rtl/pe_array_sequencer.sv
// Sequences a row of NUM_PE PEs through y = W*x, accumulating per lane and streaming
// one result tile per row block. Define PE_SEQ_RELU_EN to clamp negative lane results to 0.
module pe_array_sequencer
  import pe_seq_pkg::*;
#(
  parameter int NUM_PE     = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [15:0]                  cfg_rows_i,
  input  logic [15:0]                  cfg_cols_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         w_rd_en_o,
  output logic [ADDR_WIDTH-1:0]        w_rd_addr_o,
  output logic                         x_rd_en_o,
  output logic [ADDR_WIDTH-1:0]        x_rd_addr_o,
  output logic                         pe_clr_o,
  input  logic [NUM_PE*DATA_WIDTH-1:0] pe_y_i,
  pe_array_sequencer_if.master         out
);

  localparam logic [2:0] IDLE   = S_IDLE;
  localparam logic [2:0] ISSUE  = S_ISSUE;
  localparam logic [2:0] DRAIN  = S_DRAIN;
  localparam logic [2:0] OUTPUT = S_OUTPUT;
  localparam logic [2:0] DONE   = S_DONE;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] lane_out(input logic signed [ACC_WIDTH-1:0] a,
                                                            input logic keep);
    logic signed [ACC_WIDTH-1:0] r;
    r = keep ? a : '0;
`ifdef PE_SEQ_RELU_EN
    if (r < 0) r = '0;
`endif
    return r;
  endfunction

  logic [2:0]                  state;
  logic [15:0]                 rows_q, cols_q;
  logic [ADDR_WIDTH-1:0]       w_addr, x_addr;
  logic [15:0]                 row_base;
  logic                        first_k, last_k, last_tile;
  logic                        issue, load, step_tile, cfg_zero;
  logic                        vld_p0, vld_p1, first_p0, first_p1;
  logic signed [ACC_WIDTH-1:0] acc [NUM_PE];
  logic [NUM_PE*ACC_WIDTH-1:0] data_vec;

  assign issue     = (state == ISSUE);
  assign load      = (state == IDLE) && start_i;
  assign step_tile = (state == OUTPUT) && out.out_ready_i;
  assign cfg_zero  = (cfg_rows_i == 16'd0) || (cfg_cols_i == 16'd0);

  pe_seq_addr_gen #(
    .NUM_PE     (NUM_PE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step_k    (issue),
    .step_tile (step_tile),
    .rows      (rows_q),
    .cols      (cols_q),
    .w_addr    (w_addr),
    .x_addr    (x_addr),
    .row_base  (row_base),
    .first_k   (first_k),
    .last_k    (last_k),
    .last_tile (last_tile)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rows_q <= '0;
      cols_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            rows_q <= cfg_rows_i;
            cols_q <= cfg_cols_i;
            state  <= cfg_zero ? DONE : ISSUE;
          end
        end
        ISSUE:  if (last_k) state <= DRAIN;
        // the last product lands in acc on the same edge vld_p0 is seen empty
        DRAIN:  if (!vld_p0) state <= OUTPUT;
        OUTPUT: if (out.out_ready_i) state <= last_tile ? DONE : ISSUE;
        DONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // stage p0: buffer read data in flight; stage p1: pe_y_i valid for this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
    end else begin
      vld_p0   <= issue;
      first_p0 <= issue && first_k;
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
    end
  end

  // accumulate stage: first product of a tile overwrites, the rest add with wrap-around
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PE; i++) acc[i] <= '0;
    end else if (vld_p1) begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (first_p1) acc[i] <= sext(pe_y_i[i*DATA_WIDTH +: DATA_WIDTH]);
        else          acc[i] <= acc[i] + sext(pe_y_i[i*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  always_comb begin
    data_vec = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      logic keep;
      keep = ({1'b0, row_base} + 17'(i)) < {1'b0, rows_q};
      if (state == OUTPUT) data_vec[i*ACC_WIDTH +: ACC_WIDTH] = lane_out(acc[i], keep);
    end
  end

  assign busy_o          = (state != IDLE);
  assign done_o          = (state == DONE);
  assign w_rd_en_o       = issue;
  assign x_rd_en_o       = issue;
  assign w_rd_addr_o     = issue ? w_addr : '0;
  assign x_rd_addr_o     = issue ? x_addr : '0;
  assign pe_clr_o        = vld_p1 && first_p1;
  assign out.out_valid_o = (state == OUTPUT);
  assign out.out_data_o  = data_vec;
  assign out.out_row_o   = (state == OUTPUT) ? row_base : 16'd0;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Bench for pe_array_sequencer: PE/buffer latency model, result scoreboard and read-address tracker.
module tb_pe_array_sequencer;
  import pe_seq_pkg::*;

  localparam int NP  = 8;
  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int ADW = 16;
  localparam int CW  = NP*AW;
  typedef logic [CW-1:0] cv_t;

  typedef struct {
    int rows; int cols; int mode; int stall; bit hold; int tiles;
  } vec_t;

  typedef struct {
    logic [15:0] row;
    cv_t         data;
  } tile_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic [15:0]     cfg_rows_i, cfg_cols_i;
  logic            busy_o, done_o, w_rd_en_o, x_rd_en_o, pe_clr_o;
  logic [ADW-1:0]  w_rd_addr_o, x_rd_addr_o;
  logic [NP*DW-1:0] pe_y_i;

  pe_array_sequencer_if #(.NUM_PE(NP), .ACC_WIDTH(AW)) out_if ();

  pe_array_sequencer #(.NUM_PE(NP), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .cfg_rows_i  (cfg_rows_i),
    .cfg_cols_i  (cfg_cols_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .w_rd_en_o   (w_rd_en_o),
    .w_rd_addr_o (w_rd_addr_o),
    .x_rd_en_o   (x_rd_en_o),
    .x_rd_addr_o (x_rd_addr_o),
    .pe_clr_o    (pe_clr_o),
    .pe_y_i      (pe_y_i),
    .out         (out_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cur_rows = 0, cur_cols = 0, cur_mode = 0, stall_cfg = 0, stall_left = 0;
  int trk_k = 0, trk_tile = 0, trk_reads = 0, hs_cnt = 0, clr_cnt = 0;
  bit holding = 0;
  cv_t held_data;
  logic [15:0] held_row;
  tile_t exp_q[$];
  vec_t tbl [7];

  task automatic check(input string name, input cv_t act, input cv_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] prod(input int mode, input int lane, input int w, input int x);
    case (mode)
      0:       return 8'd3;
      1:       return 8'hFF;
      2:       return 8'(w*5 + lane*7 - x*3 + 1);
      default: return (lane % 2 == 0) ? 8'hFB : 8'h06;
    endcase
  endfunction

  // PE row + buffers: read in cycle t shows up on pe_y_i in t+2; junk otherwise
  logic           d1_en, d2_en;
  logic [ADW-1:0] d1_w, d1_x, d2_w, d2_x;
  always @(posedge clk) begin
    d1_en <= w_rd_en_o;  d1_w <= w_rd_addr_o; d1_x <= x_rd_addr_o;
    d2_en <= d1_en;      d2_w <= d1_w;        d2_x <= d1_x;
  end
  always_comb begin
    pe_y_i = '0;
    for (int i = 0; i < NP; i++)
      pe_y_i[i*DW +: DW] = (d2_en === 1'b1) ? prod(cur_mode, i, int'(d2_w), int'(d2_x)) : 8'h5A;
  end

  // downstream: stall_cfg cycles of back-pressure on every tile
  initial begin
    out_if.out_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (out_if.out_valid_o !== 1'b1) begin
        stall_left = stall_cfg;
        out_if.out_ready_i = 1'b1;
      end else if (stall_left > 0) begin
        stall_left--;
        out_if.out_ready_i = 1'b0;
      end else begin
        out_if.out_ready_i = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (w_rd_en_o === 1'b1) begin
        check("w_addr", cv_t'(w_rd_addr_o), cv_t'(ADW'(trk_tile*cur_cols + trk_k)));
        check("x_addr", cv_t'(x_rd_addr_o), cv_t'(ADW'(trk_k)));
        check("x_en", cv_t'(x_rd_en_o), cv_t'(1));
        check("rd_during_output", cv_t'(out_if.out_valid_o), cv_t'(0));
        trk_reads++;
        trk_k++;
        if (trk_k == cur_cols) begin trk_k = 0; trk_tile++; end
      end
      if (pe_clr_o === 1'b1) clr_cnt++;
      if (out_if.out_valid_o === 1'b1) begin
        if (out_if.out_ready_i !== 1'b1) begin
          if (holding) begin
            check("hold_data", out_if.out_data_o, held_data);
            check("hold_row", cv_t'(out_if.out_row_o), cv_t'(held_row));
          end else begin
            holding   = 1;
            held_data = out_if.out_data_o;
            held_row  = out_if.out_row_o;
          end
        end else begin
          holding = 0;
          hs_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_tile", cv_t'(out_if.out_valid_o), cv_t'(0));
          end else begin
            tile_t e;
            e = exp_q.pop_front();
            check("out_row", cv_t'(out_if.out_row_o), cv_t'(e.row));
            check("out_data", out_if.out_data_o, e.data);
          end
        end
      end
    end
  end

  task automatic push_expected();
    int tiles;
    tiles = (cur_cols == 0) ? 0 : (cur_rows + NP - 1) / NP;
    for (int t = 0; t < tiles; t++) begin
      tile_t e;
      e.row  = 16'(t*NP);
      e.data = '0;
      for (int i = 0; i < NP; i++) begin
        acc_t s;
        s = '0;
        if (t*NP + i < cur_rows) begin
          for (int k = 0; k < cur_cols; k++) begin
            logic [7:0] p;
            p = prod(cur_mode, i, t*cur_cols + k, k);
            s = s + {{24{p[7]}}, p};
          end
        end
`ifdef PE_SEQ_RELU_EN
        if (s < 0) s = '0;
`endif
        e.data[i*AW +: AW] = s;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic start_layer(input int rows, input int cols, input int mode, input int stall, input bit hold);
    cur_rows = rows; cur_cols = cols; cur_mode = mode; stall_cfg = stall;
    trk_k = 0; trk_tile = 0; trk_reads = 0; hs_cnt = 0; clr_cnt = 0; holding = 0;
    exp_q.delete();
    push_expected();
    cfg_rows_i = 16'(rows);
    cfg_cols_i = 16'(cols);
    start_i = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, exp_lat;
    bit seen;
    start_layer(v.rows, v.cols, v.mode, v.stall, v.hold);
    exp_lat = (v.rows == 0 || v.cols == 0) ? 1 : v.tiles*(v.cols + 3 + v.stall) + 1;
    cyc = 1;
    seen = 0;
    check("busy_after_start", cv_t'(busy_o), cv_t'(1));
    while (!seen && cyc <= 2000) begin
      if (done_o === 1'b1) seen = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    check("done_seen", cv_t'(seen), cv_t'(1));
    check("done_latency", cv_t'(cyc), cv_t'(exp_lat));
    check("busy_at_done", cv_t'(busy_o), cv_t'(1));
    start_i = 1'b0;
    @(posedge clk); #1;
    check("done_pulse", cv_t'(done_o), cv_t'(0));
    check("busy_drop", cv_t'(busy_o), cv_t'(0));
    check("tile_count", cv_t'(hs_cnt), cv_t'(v.tiles));
    check("clr_count", cv_t'(clr_cnt), cv_t'(v.tiles));
    check("read_count", cv_t'(trk_reads), cv_t'(v.tiles*v.cols));
    check("queue_empty", cv_t'(exp_q.size()), cv_t'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, cv_t'(busy_o), cv_t'(0));
    check({tag, "_done"}, cv_t'(done_o), cv_t'(0));
    check({tag, "_w_en"}, cv_t'(w_rd_en_o), cv_t'(0));
    check({tag, "_w_addr"}, cv_t'(w_rd_addr_o), cv_t'(0));
    check({tag, "_x_en"}, cv_t'(x_rd_en_o), cv_t'(0));
    check({tag, "_x_addr"}, cv_t'(x_rd_addr_o), cv_t'(0));
    check({tag, "_clr"}, cv_t'(pe_clr_o), cv_t'(0));
    check({tag, "_valid"}, cv_t'(out_if.out_valid_o), cv_t'(0));
    check({tag, "_data"}, out_if.out_data_o, cv_t'(0));
    check({tag, "_row"}, cv_t'(out_if.out_row_o), cv_t'(0));
  endtask

  initial begin
    vec_t after_rst;
    rst = 1'b1;
    start_i = 1'b0;
    cfg_rows_i = '0;
    cfg_cols_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    tbl[0] = '{rows: 8,  cols: 4, mode: 0, stall: 0, hold: 1'b0, tiles: 1};
    tbl[1] = '{rows: 10, cols: 2, mode: 1, stall: 0, hold: 1'b0, tiles: 2};
    tbl[2] = '{rows: 16, cols: 3, mode: 2, stall: 5, hold: 1'b0, tiles: 2};
    tbl[3] = '{rows: 0,  cols: 4, mode: 0, stall: 0, hold: 1'b0, tiles: 0};
    tbl[4] = '{rows: 5,  cols: 0, mode: 0, stall: 0, hold: 1'b0, tiles: 0};
    tbl[5] = '{rows: 8,  cols: 1, mode: 3, stall: 0, hold: 1'b1, tiles: 1};
    tbl[6] = '{rows: 20, cols: 5, mode: 2, stall: 1, hold: 1'b0, tiles: 3};
    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // abort mid-ISSUE with reset, then a fresh single-k layer
    start_layer(16, 6, 2, 0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("abort_in_issue", cv_t'(w_rd_en_o), cv_t'(1));
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    check_all_zero("mid_reset_held");
    rst = 1'b0;
    after_rst = '{rows: 8, cols: 1, mode: 2, stall: 0, hold: 1'b0, tiles: 1};
    run_vec(after_rst);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
